// File: rtl/snn_frame_seq_pkg.sv
// Shared types and default widths for the SNN per-frame sequencer.
package snn_frame_seq_pkg;

  localparam int SNN_PACKET_WIDTH    = 30;
  localparam int SNN_OUT_ID_WIDTH    = 8;
  localparam int SNN_NUM_OUTPUT      = 250;
  localparam int SNN_PKT_CNT_WIDTH   = 12;
  localparam int SNN_CYC_WIDTH       = 20;
  localparam int SNN_FRAME_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_SETTLE,
    ST_TICK,
    ST_WAIT
  } seq_state_e;

endpackage

// File: rtl/snn_spike_accumulator.sv
// OR-accumulates grid spike IDs into a bit vector; ID 0 lands in the MSB.
module snn_spike_accumulator #(
  parameter int NUM_OUTPUT   = 250,
  parameter int OUT_ID_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_capture_en,
  input  logic [OUT_ID_WIDTH-1:0] i_id,
  input  logic                    i_valid,
  output logic [NUM_OUTPUT-1:0]   o_vector,
  output logic                    o_range_err
);

  localparam logic [OUT_ID_WIDTH:0] LP_LIMIT = (OUT_ID_WIDTH+1)'(NUM_OUTPUT);

  logic [NUM_OUTPUT-1:0] r_acc;
  logic [NUM_OUTPUT-1:0] w_hit;
  logic [NUM_OUTPUT-1:0] w_acc_nxt;
  logic                  w_take;

  assign w_take = i_valid && i_capture_en;

  for (genvar g = 0; g < NUM_OUTPUT; g++) begin : g_bit
    assign w_hit[g] = w_take && ({1'b0, i_id} == (OUT_ID_WIDTH+1)'(NUM_OUTPUT-1-g));
  end

  // Clear-then-set so a spike in the clearing cycle survives.
  assign w_acc_nxt = (i_clear ? '0 : r_acc) | w_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_acc <= '0;
    else          r_acc <= w_acc_nxt;
  end

  // Exposes the post-update value so a publish edge includes this cycle's spike.
  assign o_vector    = w_acc_nxt;
  assign o_range_err = w_take && ({1'b0, i_id} >= LP_LIMIT);

endmodule

// File: rtl/snn_frame_sequencer.sv
// Per-frame driver for the RANC grid: feed packets, settle, tick, collect spikes, publish.
module snn_frame_sequencer
  import snn_frame_seq_pkg::*;
#(
  parameter int PACKET_WIDTH    = SNN_PACKET_WIDTH,
  parameter int OUT_ID_WIDTH    = SNN_OUT_ID_WIDTH,
  parameter int NUM_OUTPUT      = SNN_NUM_OUTPUT,
  parameter int PKT_CNT_WIDTH   = SNN_PKT_CNT_WIDTH,
  parameter int CYC_WIDTH       = SNN_CYC_WIDTH,
  parameter int FRAME_CNT_WIDTH = SNN_FRAME_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_start,
  input  logic [PKT_CNT_WIDTH-1:0]   frame_num_packets,
  input  logic [CYC_WIDTH-1:0]       cfg_settle_cycles,
  input  logic [CYC_WIDTH-1:0]       cfg_tick_gap,
  input  logic                       src_valid,
  input  logic [PACKET_WIDTH-1:0]    src_data,
  output logic                       src_ready,
  output logic                       grid_input_buffer_empty,
  output logic [PACKET_WIDTH-1:0]    grid_packet_in,
  input  logic                       grid_ren,
  output logic                       grid_tick,
  input  logic [OUT_ID_WIDTH-1:0]    grid_packet_out,
  input  logic                       grid_packet_out_valid,
  output logic [NUM_OUTPUT-1:0]      spike_vec,
  output logic                       spike_vec_valid,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       id_range_err,
  output logic                       stray_spike_err
);

  seq_state_e                 r_state, w_state_nxt;
  logic [PKT_CNT_WIDTH-1:0]   r_num, r_sent, w_sent_inc;
  logic [CYC_WIDTH-1:0]       r_gap, r_cyc;
  logic [PACKET_WIDTH-1:0]    r_pkt;
  logic [NUM_OUTPUT-1:0]      r_spike_vec, w_acc_vec;
  logic                       r_vec_valid;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
  logic                       r_range_err, r_stray_err;
  logic                       w_empty, w_accept, w_publish, w_capture_en, w_range_pulse;

  assign w_empty      = !(r_state == ST_FEED && src_valid && (r_sent < r_num));
  assign w_accept     = grid_ren && !w_empty;
  assign w_sent_inc   = r_sent + 1'b1;
  assign w_capture_en = (r_state == ST_TICK) || (r_state == ST_WAIT);

  assign src_ready               = w_accept;
  assign grid_input_buffer_empty = w_empty;
  assign grid_packet_in          = r_pkt;
  assign grid_tick               = (r_state == ST_TICK);
  assign busy                    = (r_state != ST_IDLE);
  assign spike_vec               = r_spike_vec;
  assign spike_vec_valid         = r_vec_valid;
  assign frame_count             = r_frame_cnt;
  assign id_range_err            = r_range_err;
  assign stray_spike_err         = r_stray_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // SETTLE always spends one cycle before counting, so settle=0 still leaves
  // one cycle for the grid to consume the final packet ahead of the tick.
  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (frame_start)
                   w_state_nxt = (frame_num_packets == '0) ? ST_SETTLE : ST_FEED;
      ST_FEED:   if ((w_accept && w_sent_inc == r_num) || (r_sent >= r_num))
                   w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cyc == '0) w_state_nxt = ST_TICK;
      ST_TICK: begin
        if (r_gap == '0) begin
          w_publish   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cyc <= CYC_WIDTH'(1)) begin
          w_publish   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num  <= '0;
      r_sent <= '0;
      r_gap  <= '0;
      r_cyc  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (frame_start) begin
          r_num  <= frame_num_packets;
          r_gap  <= cfg_tick_gap;
          r_cyc  <= cfg_settle_cycles;
          r_sent <= '0;
        end
        ST_FEED:   if (w_accept) r_sent <= w_sent_inc;
        ST_SETTLE: if (r_cyc != '0) r_cyc <= r_cyc - 1'b1;
        ST_TICK:   r_cyc <= r_gap;
        ST_WAIT:   r_cyc <= r_cyc - 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_pkt <= '0;
    else if (w_accept) r_pkt <= src_data;
  end

  snn_spike_accumulator #(
    .NUM_OUTPUT   (NUM_OUTPUT),
    .OUT_ID_WIDTH (OUT_ID_WIDTH)
  ) u_acc (
    .i_clk        (clk),
    .i_rst_n      (reset_n),
    .i_clear      (r_state == ST_TICK),
    .i_capture_en (w_capture_en),
    .i_id         (grid_packet_out),
    .i_valid      (grid_packet_out_valid),
    .o_vector     (w_acc_vec),
    .o_range_err  (w_range_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_spike_vec <= '0;
      r_vec_valid <= 1'b0;
      r_frame_cnt <= '0;
      r_range_err <= 1'b0;
      r_stray_err <= 1'b0;
    end else begin
      r_vec_valid <= w_publish;
      if (w_publish) begin
        r_spike_vec <= w_acc_vec;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_range_pulse) r_range_err <= 1'b1;
      if (grid_packet_out_valid && !w_capture_en) r_stray_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snn_frame_sequencer.sv
// Bench for snn_frame_sequencer: table frames, randomized frames, async reset mid-frame.
module tb_snn_frame_sequencer;

  localparam int PW = 30, IW = 8, NO = 250, PCW = 12, CW = 20, FCW = 16;

  logic           clk = 1'b0, reset_n = 1'b0;
  logic           frame_start = 1'b0;
  logic [PCW-1:0] frame_num_packets = '0;
  logic [CW-1:0]  cfg_settle_cycles = '0, cfg_tick_gap = '0;
  logic           src_valid = 1'b0;
  logic [PW-1:0]  src_data = '0;
  logic           src_ready, grid_input_buffer_empty, grid_tick, spike_vec_valid, busy;
  logic [PW-1:0]  grid_packet_in;
  logic           grid_ren = 1'b0;
  logic [IW-1:0]  grid_packet_out = '0;
  logic           grid_packet_out_valid = 1'b0;
  logic [NO-1:0]  spike_vec;
  logic [FCW-1:0] frame_count;
  logic           id_range_err, stray_spike_err;

  snn_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .frame_num_packets(frame_num_packets), .cfg_settle_cycles(cfg_settle_cycles),
    .cfg_tick_gap(cfg_tick_gap), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .grid_input_buffer_empty(grid_input_buffer_empty),
    .grid_packet_in(grid_packet_in), .grid_ren(grid_ren), .grid_tick(grid_tick),
    .grid_packet_out(grid_packet_out), .grid_packet_out_valid(grid_packet_out_valid),
    .spike_vec(spike_vec), .spike_vec_valid(spike_vec_valid), .busy(busy),
    .frame_count(frame_count), .id_range_err(id_range_err), .stray_spike_err(stray_spike_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_frames = 0;
  bit m_range = 1'b0, m_stray = 1'b0;
  bit g_rand = 1'b0;
  int g_nsp = 0;
  int g_sp_cyc[4];
  int g_sp_id[4];

  typedef struct {
    int num, settle, gap, ren_mode, nsp;
    int c0, i0, c1, i1, c2, i2, c3, i3;
    int pub, b0, b1, b2;
    bit rng, str;
  } vec_t;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_src_ready", src_ready, 0);
    chk("rst_buf_empty", grid_input_buffer_empty, 1);
    chk("rst_pkt_in", grid_packet_in, 0);
    chk("rst_tick", grid_tick, 0);
    chk("rst_vec", spike_vec, 0);
    chk("rst_vec_valid", spike_vec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_range_err", id_range_err, 0);
    chk("rst_stray_err", stray_spike_err, 0);
  endtask

  // Model: FEED from cycle 1 until the last accept, SETTLE for settle+1 cycles,
  // a one-cycle tick, then gap collection cycles; spikes count from tick to tick+gap.
  task automatic run_frame(input int num, input int settle, input int gap, input int ren_mode,
                           input int vmode, output int obs_pub, output logic [NO-1:0] obs_vec);
    int sent = 0, tick = -1, pub = -1, dut_acc = 0, id_i;
    bit m_acc, done = 1'b0;
    logic [NO-1:0] mvec = '0;
    logic [PW-1:0] pk;
    obs_pub = -1;
    obs_vec = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      frame_start = (cyc == 0) || (g_rand && $urandom_range(0, 7) == 0);
      frame_num_packets = (cyc == 0) ? PCW'(num) : PCW'($urandom);
      cfg_settle_cycles = (cyc == 0 || !g_rand) ? CW'(settle) : CW'($urandom);
      cfg_tick_gap      = (cyc == 0 || !g_rand) ? CW'(gap) : CW'($urandom);
      src_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      src_data  = PW'($urandom);
      case (ren_mode)
        0:       grid_ren = 1'b1;
        1:       grid_ren = (cyc % 2 == 1);
        default: grid_ren = ($urandom_range(0, 2) != 0);
      endcase
      grid_packet_out_valid = 1'b0;
      grid_packet_out = '0;
      if (g_rand) begin
        if (tick >= 0 && cyc >= tick) begin
          if ($urandom_range(0, 2) == 0) begin
            id_i = ($urandom_range(0, 9) == 0) ? 250 + int'($urandom_range(0, 5))
                                               : int'($urandom_range(0, 249));
            grid_packet_out_valid = 1'b1;
            grid_packet_out = IW'(id_i);
          end
        end else if ($urandom_range(0, 29) == 0) begin
          grid_packet_out_valid = 1'b1;
          grid_packet_out = IW'($urandom_range(0, 249));
        end
      end else begin
        for (int k = 0; k < g_nsp; k++)
          if (g_sp_cyc[k] == cyc) begin
            grid_packet_out_valid = 1'b1;
            grid_packet_out = IW'(g_sp_id[k]);
          end
      end
      m_acc = (cyc >= 1) && (sent < num) && src_valid && grid_ren;
      if (grid_packet_out_valid) begin
        id_i = int'(grid_packet_out);
        if (tick >= 0 && cyc >= tick && cyc <= tick + gap) begin
          if (id_i < NO) mvec[NO-1-id_i] = 1'b1;
          else m_range = 1'b1;
        end else m_stray = 1'b1;
      end
      pk = src_data;
      @(negedge clk);
      chk("src_ready", src_ready, m_acc);
      chk("buf_empty", grid_input_buffer_empty, !((cyc >= 1) && (sent < num) && src_valid));
      chk("grid_tick", grid_tick, cyc == tick);
      chk("busy", busy, cyc >= 1);
      if (src_ready) dut_acc++;
      @(posedge clk);
      #1;
      if (m_acc) begin
        chk("pkt_in", grid_packet_in, pk);
        sent++;
        if (sent == num) tick = cyc + 2 + settle;
      end
      if (num == 0 && cyc == 0) tick = 2 + settle;
      if (tick >= 0) pub = tick + gap + 1;
      chk("vec_valid", spike_vec_valid, cyc + 1 == pub);
      if (spike_vec_valid) begin
        obs_pub = cyc + 1;
        obs_vec = spike_vec;
        done = 1'b1;
      end
      if (pub >= 0 && cyc + 1 >= pub) done = 1'b1;
    end
    frame_start = 1'b0;
    src_valid = 1'b0;
    grid_ren = 1'b0;
    grid_packet_out_valid = 1'b0;
    total++;
    if (obs_pub < 0) begin
      bad++;
      $display("FAIL publish_timeout actual=none expected=cycle %0d", pub);
    end else begin
      m_frames++;
      chk("spike_vec", obs_vec, mvec);
      chk("frame_count", frame_count, FCW'(m_frames));
      chk("busy_after", busy, 0);
    end
    chk("accept_count", dut_acc, num);
    chk("range_err", id_range_err, m_range);
    chk("stray_err", stray_spike_err, m_stray);
  endtask

  vec_t tbl[5];
  int obs_pub;
  logic [NO-1:0] obs_vec, ev;
  logic [PW-1:0] d2;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  3, -1, -1, -1, 1'b0, 1'b0};
    tbl[1] = '{3, 2, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  11, -1, -1, -1, 1'b0, 1'b0};
    tbl[2] = '{2, 1, 10, 0, 4, 7, 0, 9, 249, 10, 5, 12, 5,  16, 249, 0, 244, 1'b0, 1'b0};
    tbl[3] = '{1, 0, 3, 0, 2,  3, 3, 6, 7, 0, 0, 0, 0,  7, 246, 242, -1, 1'b0, 1'b0};
    tbl[4] = '{4, 0, 2, 0, 2,  2, 1, 7, 250, 0, 0, 0, 0,  9, -1, -1, -1, 1'b1, 1'b1};

    #12;
    chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      g_rand = 1'b0;
      g_nsp = tbl[t].nsp;
      g_sp_cyc[0] = tbl[t].c0; g_sp_id[0] = tbl[t].i0;
      g_sp_cyc[1] = tbl[t].c1; g_sp_id[1] = tbl[t].i1;
      g_sp_cyc[2] = tbl[t].c2; g_sp_id[2] = tbl[t].i2;
      g_sp_cyc[3] = tbl[t].c3; g_sp_id[3] = tbl[t].i3;
      run_frame(tbl[t].num, tbl[t].settle, tbl[t].gap, tbl[t].ren_mode, 0, obs_pub, obs_vec);
      ev = '0;
      if (tbl[t].b0 >= 0) ev[tbl[t].b0] = 1'b1;
      if (tbl[t].b1 >= 0) ev[tbl[t].b1] = 1'b1;
      if (tbl[t].b2 >= 0) ev[tbl[t].b2] = 1'b1;
      chk($sformatf("tbl%0d_pub_cycle", t), obs_pub, tbl[t].pub);
      chk($sformatf("tbl%0d_vec", t), obs_vec, ev);
      chk($sformatf("tbl%0d_range", t), id_range_err, tbl[t].rng);
      chk($sformatf("tbl%0d_stray", t), stray_spike_err, tbl[t].str);
    end

    g_rand = 1'b1;
    for (int r = 0; r < 30; r++)
      run_frame($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 6),
                $urandom_range(0, 2), $urandom_range(0, 1), obs_pub, obs_vec);

    // Reset while two of five packets have been handed over.
    frame_start = 1'b1; frame_num_packets = 5; cfg_settle_cycles = 0; cfg_tick_gap = 0;
    src_valid = 1'b1; grid_ren = 1'b1; src_data = 30'h0111_1111;
    @(posedge clk); #1;
    frame_start = 1'b0; src_data = 30'h0222_2222;
    @(posedge clk); #1;
    d2 = 30'h0333_3333;
    src_data = d2;
    @(posedge clk); #1;
    chk("mid_pkt_in", grid_packet_in, d2);
    chk("mid_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    src_valid = 1'b0; grid_ren = 1'b0;
    m_frames = 0; m_range = 1'b0; m_stray = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_valid", spike_vec_valid, 0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_valid", spike_vec_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    @(posedge clk); #1;
    g_rand = 1'b1;
    run_frame(2, 1, 2, 0, 0, obs_pub, obs_vec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
